// File: rtl/unpack_pkg.sv
// Shared definitions for the 20 x 11-bit unpacked register array and its
// read-side scan engine.
//   DEPTH / WIDTH / AW : array geometry (entries, entry width, index width)
//   state_e            : scan engine states
//   clamp_idx          : out-of-range index -> 0, shared with the write port
package unpack_pkg;

  localparam int unsigned DEPTH = 20;
  localparam int unsigned WIDTH = 11;
  localparam int unsigned AW    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Indices at or beyond the array depth alias to entry 0.
  function automatic logic [AW-1:0] clamp_idx(input logic [AW-1:0] idx,
                                              input int unsigned   depth = DEPTH);
    return (32'(idx) >= depth) ? '0 : idx;
  endfunction

endpackage

// File: rtl/unpack_max_acc.sv
// Running maximum / argmax register.
//   ck, rst        : clock, synchronous active-high reset
//   clr            : zero both value and index (wins over en)
//   en, val, idx   : candidate entry; taken only if val is strictly greater
//   max_val/max_idx: current maximum and the index it came from
module unpack_max_acc #(
  parameter int unsigned WIDTH = unpack_pkg::WIDTH,
  parameter int unsigned AW    = unpack_pkg::AW
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] val,
  input  logic [AW-1:0]    idx,
  output logic [WIDTH-1:0] max_val,
  output logic [AW-1:0]    max_idx
);

  logic [WIDTH-1:0] max_val_q, max_val_d;
  logic [AW-1:0]    max_idx_q, max_idx_d;

  // Strict compare: on ties the earlier (lower) index is kept.
  always_comb begin
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    if (clr) begin
      max_val_d = '0;
      max_idx_d = '0;
    end else if (en && (val > max_val_q)) begin
      max_val_d = val;
      max_idx_d = idx;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign max_val = max_val_q;
  assign max_idx = max_idx_q;

endmodule

// File: rtl/unpack_scan.sv
// Sequential read-side scan of the unpacked register array.
// Walks an inclusive index range through the array's combinational read
// port, streams each entry on a valid/ready port and tracks max/argmax.
//   ck, rst                 : clock, synchronous active-high reset
//   start, first, last      : scan request and inclusive range (IDLE only)
//   busy                    : scan in progress
//   rd_idx, rd_data         : array read address / same-cycle read data
//   out_valid, out_ready    : output handshake
//   out_data, out_idx, out_last : beat payload
//   done                    : one-cycle pulse at scan completion
//   max_val, max_idx        : max of the last completed scan and its index
module unpack_scan #(
  parameter int unsigned DEPTH = unpack_pkg::DEPTH,
  parameter int unsigned WIDTH = unpack_pkg::WIDTH,
  parameter int unsigned AW    = unpack_pkg::AW
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    first,
  input  logic [AW-1:0]    last,
  output logic             busy,
  output logic [AW-1:0]    rd_idx,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_idx,
  output logic             out_last,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [AW-1:0]    max_idx
);

  import unpack_pkg::*;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    end_idx_q, end_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]    out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic [AW-1:0]    rd_idx_c;
  logic             acc_clr;
  logic             load;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_idx_d   = end_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    rd_idx_c    = '0;
    acc_clr     = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d     = clamp_idx(first, DEPTH);
          end_idx_d = clamp_idx(last, DEPTH);
          acc_clr   = 1'b1;
          // Empty range finishes immediately with no beats.
          if (ptr_d > end_idx_d) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        rd_idx_c = ptr_q;
        // Load whenever the output slot is empty or being drained this cycle.
        if (!out_valid_q || out_ready) begin
          load        = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
          out_idx_d   = ptr_q;
          out_last_d  = (ptr_q == end_idx_q);
          ptr_d       = ptr_q + AW'(1);
          if (ptr_q == end_idx_q) begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      end_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      end_idx_q   <= end_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  unpack_max_acc #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_max_acc (
    .ck      (ck),
    .rst     (rst),
    .clr     (acc_clr),
    .en      (load),
    .val     (rd_data),
    .idx     (ptr_q),
    .max_val (max_val),
    .max_idx (max_idx)
  );

  assign busy      = (state_q != StIdle);
  assign rd_idx    = rd_idx_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_unpack_scan.sv
// Scoreboard bench for unpack_scan: the driver pushes expected beats and the
// expected done result when it issues start; a negedge monitor pops and
// compares on every handshake and done pulse.
module tb_unpack_scan;

  logic        ck;
  logic        rst;
  logic        start;
  logic [4:0]  first;
  logic [4:0]  last;
  logic        busy;
  logic [4:0]  rd_idx;
  logic [10:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        done;
  logic [10:0] max_val;
  logic [4:0]  max_idx;

  // Array model: written directly by the bench, read combinationally.
  logic [10:0] mem [20];
  assign rd_data = (rd_idx < 5'd20) ? mem[rd_idx] : 11'd0;

  unpack_scan dut (
    .ck        (ck),
    .rst       (rst),
    .start     (start),
    .first     (first),
    .last      (last),
    .busy      (busy),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done),
    .max_val   (max_val),
    .max_idx   (max_idx)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] data;
    int          idx;
    bit          last;
  } beat_t;

  typedef struct {
    int val;
    int idx;
    int exp_cyc;
    int k;
  } done_t;

  beat_t beatq[$];
  done_t doneq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int done_target = 0;
  int first_valid_cyc = -1;
  int last_hs_cyc = -1;
  bit rdy_rand = 1'b0;
  bit bp_pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: clamp the range, list the entries in order, keep the
  // first strictly-greater maximum starting from 0/0.
  task automatic push_model(input int f, input int l, input bit hold, input int n,
                            output int k);
    int a, b, mv, mi;
    beat_t bt;
    done_t dt;
    a  = (f >= 20) ? 0 : f;
    b  = (l >= 20) ? 0 : l;
    mv = 0;
    mi = 0;
    k  = 0;
    for (int i = a; i <= b; i++) begin
      bt.data = mem[i];
      bt.idx  = i;
      bt.last = (i == b);
      beatq.push_back(bt);
      if (int'(mem[i]) > mv) begin
        mv = int'(mem[i]);
        mi = i;
      end
      k++;
    end
    dt.val     = mv;
    dt.idx     = mi;
    dt.k       = k;
    dt.exp_cyc = !hold ? -1 : ((k == 0) ? n + 1 : n + 2 + k);
    doneq.push_back(dt);
  endtask

  // Monitor: outputs sampled on the falling edge, mid-cycle.
  bit          prev_stall = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_done = 1'b0;
  logic [10:0] prev_data;
  logic [4:0]  prev_idx;
  logic        prev_last;

  always @(negedge ck) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check(out_valid == 1'b1, "valid_held", int'(out_valid), 1);
        check(out_data == prev_data, "data_held", int'(out_data), int'(prev_data));
        check(out_idx == prev_idx, "idx_held", int'(out_idx), int'(prev_idx));
        check(out_last == prev_last, "last_held", int'(out_last), int'(prev_last));
      end
      if (out_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid) begin
        check(beatq.size() > 0, "beat_expected", int'(out_idx), -1);
        if (out_ready && beatq.size() > 0) begin
          beat_t b;
          b = beatq.pop_front();
          check(out_data == b.data, "beat_data", int'(out_data), int'(b.data));
          check(int'(out_idx) == b.idx, "beat_idx", int'(out_idx), b.idx);
          check(out_last == b.last, "beat_last", int'(out_last), int'(b.last));
          if (b.last) last_hs_cyc = cyc;
        end
      end
      if (prev_done) check(done == 1'b0, "done_pulse", int'(done), 0);
      if (done) begin
        done_seen++;
        check(doneq.size() > 0, "done_expected", done_seen, done_target);
        if (doneq.size() > 0) begin
          done_t d;
          d = doneq.pop_front();
          check(int'(max_val) == d.val, "max_val", int'(max_val), d.val);
          check(int'(max_idx) == d.idx, "max_idx", int'(max_idx), d.idx);
          check(busy == 1'b0, "busy_at_done", int'(busy), 0);
          if (d.exp_cyc >= 0) check(cyc == d.exp_cyc, "done_cycle", cyc, d.exp_cyc);
          if (d.k > 0) check(cyc == last_hs_cyc + 1, "done_after_last", cyc, last_hs_cyc + 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_done  = done;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_last  = out_last;
    end
  end

  // Random backpressure source, active only while rdy_rand is set.
  initial forever begin
    @(posedge ck);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue_start(input int f, input int l, input bit hold,
                             output int n, output int k, output int tgt);
    @(posedge ck);
    #1;
    first = 5'(f);
    last  = 5'(l);
    start = 1'b1;
    n     = cyc;
    first_valid_cyc = -1;
    push_model(f, l, hold, n, k);
    done_target++;
    tgt = done_target;
    @(posedge ck);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int tgt);
    int t = 0;
    while (done_seen < tgt && t < 500) begin
      @(posedge ck);
      t++;
    end
    check(done_seen >= tgt, "done_timeout", done_seen, tgt);
  endtask

  // mode 0: ready held high, 1: random ready, 2: fixed backpressure pattern
  task automatic do_scan(input int f, input int l, input int mode);
    int n, k, tgt;
    out_ready = (mode == 2) ? 1'b0 : 1'b1;
    rdy_rand  = (mode == 1);
    issue_start(f, l, mode == 0, n, k, tgt);
    if (mode == 2) begin
      for (int i = 0; i < 6; i++) begin
        @(posedge ck);
        #1;
        out_ready = bp_pat[i];
      end
    end
    wait_done(tgt);
    rdy_rand = 1'b0;
    @(posedge ck);
    #1;
    out_ready = 1'b1;
    if (mode == 0 && k > 0) check(first_valid_cyc == n + 2, "first_valid", first_valid_cyc, n + 2);
    check(beatq.size() == 0, "beats_drained", beatq.size(), 0);
  endtask

  initial begin
    int n, k, tgt;
    rst       = 1'b1;
    start     = 1'b0;
    first     = '0;
    last      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) mem[i] = 11'((i * 7) % 20);
    repeat (3) @(posedge ck);
    #1;
    rst = 1'b0;

    check(out_valid == 1'b0, "rst_valid", int'(out_valid), 0);
    check(out_last == 1'b0, "rst_last", int'(out_last), 0);
    check(out_data == 11'd0, "rst_data", int'(out_data), 0);
    check(out_idx == 5'd0, "rst_idx", int'(out_idx), 0);
    check(busy == 1'b0 && done == 1'b0, "rst_busy_done", int'({busy, done}), 0);
    check(rd_idx == 5'd0, "rst_rd_idx", int'(rd_idx), 0);
    check(max_val == 11'd0 && max_idx == 5'd0, "rst_max", int'(max_val), 0);

    // Full range over (i*7)%20: maximum 19 sits at index 17.
    do_scan(0, 19, 0);
    check(max_val == 11'd19, "full_max_val", int'(max_val), 19);
    check(max_idx == 5'd17, "full_max_idx", int'(max_idx), 17);

    // Backpressure with ready pattern 0,1,0,0,1,1.
    do_scan(3, 5, 2);

    // Tie: lowest index wins.
    for (int i = 0; i < 20; i++) mem[i] = 11'($urandom_range(0, 11'h7FE));
    mem[4] = 11'h7FF;
    mem[9] = 11'h7FF;
    do_scan(4, 9, 0);
    check(max_idx == 5'd4, "tie_idx", int'(max_idx), 4);

    // Clamp: first=25 aliases to 0.
    do_scan(25, 2, 0);

    // Empty range.
    do_scan(10, 5, 0);
    check(max_val == 11'd0 && max_idx == 5'd0, "empty_max", int'(max_val), 0);

    // Reset during a full scan.
    out_ready = 1'b1;
    issue_start(0, 19, 1'b1, n, k, tgt);
    repeat (4) @(posedge ck);
    #1;
    rst = 1'b1;
    @(posedge ck);
    #1;
    rst = 1'b0;
    check(out_valid == 1'b0, "midrst_valid", int'(out_valid), 0);
    check(busy == 1'b0, "midrst_busy", int'(busy), 0);
    check(max_val == 11'd0, "midrst_max", int'(max_val), 0);
    beatq.delete();
    doneq.delete();
    done_target = done_seen;
    repeat (30) @(posedge ck);
    #1;
    check(done_seen == done_target, "midrst_no_done", done_seen, done_target);
    do_scan(0, 19, 0);

    // Start while busy is ignored.
    out_ready = 1'b1;
    issue_start(5, 8, 1'b1, n, k, tgt);
    @(posedge ck);
    #1;
    first = 5'd0;
    last  = 5'd19;
    start = 1'b1;
    @(posedge ck);
    #1;
    start = 1'b0;
    wait_done(tgt);
    repeat (4) @(posedge ck);
    #1;
    check(busy == 1'b0, "busy_start_ignored", int'(busy), 0);
    check(done_seen == tgt, "single_done", done_seen, tgt);
    check(beatq.size() == 0, "busy_beats_drained", beatq.size(), 0);

    // Randomized scans.
    for (int s = 0; s < 40; s++) begin
      for (int w = 0; w < 6; w++) begin
        if ($urandom_range(0, 1) == 0) mem[$urandom_range(0, 19)] = 11'($urandom_range(0, 15));
        else mem[$urandom_range(0, 19)] = 11'($urandom);
      end
      do_scan(int'($urandom_range(0, 31)), int'($urandom_range(0, 24)),
              int'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge ck);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unpack_scan.md
# unpack_scan

Sequential read-side engine for the 20-entry × 11-bit unpacked register array. The array is written by the existing write port, which has an `idx`/`wr`/`data` interface and a combinational read. On `start`, this block walks an inclusive index range of the array through the array's combinational read port. It streams each entry out on a valid/ready interface and accumulates the maximum value and its index, reporting both with a one-cycle `done` pulse. It sits between the array and any consumer that needs bulk readout or a max search.

## Interface
Parameters:
- `DEPTH`, 20, number of array entries.
- `WIDTH`, 11, entry width.
- `AW`, 5, index width.

Ports:
- `ck` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a scan. Sampled only in IDLE.
- `first` in AW: first index of the range, latched on `start`.
- `last` in AW: last index of the range (inclusive), latched on `start`.
- `busy` out 1: high in RUN and DRAIN.
- `rd_idx` out AW: read address to the array.
- `rd_data` in WIDTH: combinational array read, valid in the same cycle as `rd_idx`.
- `out_valid` out 1: output beat present.
- `out_ready` in 1: consumer accepts the beat.
- `out_data` out WIDTH: entry value.
- `out_idx` out AW: index the entry was read from.
- `out_last` out 1: final beat of the scan.
- `done` out 1: one-cycle pulse when the scan completes.
- `max_val` out WIDTH: maximum value of the last completed scan.
- `max_idx` out AW: index of `max_val`.

## Operation
- **Index clamp.** Any `first`/`last` value ≥ DEPTH is replaced by 0 at latch time. This matches the write port's clamp.
- **States.** IDLE, RUN, DRAIN.
- **IDLE.**
  - `rd_idx`=0 and `busy`=0.
  - On `start`, latch `ptr`=clamp(`first`) and `end`=clamp(`last`), and clear the max/argmax accumulators to 0/0.
  - If `ptr`>`end` (empty range), stay in IDLE and pulse `done` next cycle. No beats are produced and `max_val`/`max_idx` read 0/0.
  - Otherwise go to RUN.
- **RUN.**
  - `rd_idx`=`ptr`.
  - The output register loads when `!out_valid || out_ready`. It takes `out_data`=`rd_data`, `out_idx`=`ptr` and `out_last`=(`ptr`==`end`), then sets `out_valid`=1.
  - On each load, `ptr` increments.
  - If the loaded beat was the last one, go to DRAIN.
- **DRAIN.** Hold the final beat until `out_ready`. On that handshake, clear `out_valid`, pulse `done` the next cycle, and go to IDLE.
- **Handshake.** Once `out_valid` is asserted, `out_data`, `out_idx` and `out_last` stay stable until accepted. `out_valid` never drops without a handshake, except on `rst`.
- **Max accumulator.**
  - Updated on every load, comparing unsigned values.
  - A strict greater-than compare is used, so on ties the lowest index wins.
  - `max_val`/`max_idx` hold their values from `done` until the next accepted `start`.
- **Ignored inputs.** `start` while `busy` is ignored. `first`/`last` changes after the latch have no effect.
- **Reset.**
  - `rst` at any time forces IDLE.
  - Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `out_idx`=0, `done`=0, `busy`=0, `rd_idx`=0, `max_val`=0, `max_idx`=0.
  - A scan interrupted by `rst` produces no `done`.
- **Concurrent writes.** Writes to the array during a scan are not blocked. A beat reflects the array contents in the cycle its entry was loaded.

## Timing
- `start` accepted at cycle N → `busy` and `rd_idx`=`first` at N+1 → first `out_valid` at N+2.
- Throughput is one beat per cycle while `out_ready`=1.
- For a K-entry range with `out_ready` held at 1:
  - the last beat is accepted at N+1+K;
  - `done` is asserted at N+2+K;
  - `busy` falls at N+2+K.
- For an empty range, `done` is asserted at N+1 and `busy` never rises.
- `out_ready` low stalls `ptr` and holds the output register. There is no bubble on release.
- `rd_data` is used only in the cycle it is addressed. This is a single combinational path from `rd_idx` to the output register.

## Structure
- **Shared package `unpack_pkg`:**
  - the `DEPTH`, `WIDTH` and `AW` constants;
  - the state enum {IDLE, RUN, DRAIN};
  - the clamp function (index ≥ DEPTH → 0), which the write port also uses.
- **Sub-module `unpack_max_acc`:** the running max/argmax register with clear, load-enable and a strict-greater compare.
- **Top level:** the FSM, the pointer and the output register.

## Test plan
- **Full range.** Array preloaded with entries i = (i*7)%20. Set `first`=0, `last`=19, `out_ready`=1, `start` at N.
  - Expect 20 beats at N+2..N+21, `out_idx` 0..19, `out_last` only on idx 19.
  - Expect `done` at N+22 with `max_val`=19 and `max_idx`=17.
- **Backpressure.** Set `first`=3, `last`=5 and toggle `out_ready` as 0,1,0,0,1,1.
  - Expect exactly 3 beats (idx 3, 4, 5) with stable data while stalled.
  - Expect `done` one cycle after the idx-5 handshake.
- **Tie and clamp.**
  - Entries 4 and 9 both hold 0x7FF. Set `first`=4, `last`=9 → expect `max_idx`=4.
  - Set `first`=25 and `last`=2 → the range clamps to 0..2.
- **Empty range.** Set `first`=10, `last`=5, `start` at N.
  - Expect no `out_valid`, `done` at N+1, and `max_val`/`max_idx` = 0/0.
- **Reset mid-scan.** Assert `rst` at N+5 of a 0..19 scan.
  - Expect `out_valid`=0, `busy`=0, `max_val`=0 next cycle and no `done`.
  - A new `start` afterwards completes normally.
- **Start while busy.** Pulse `start` with `first`=0 during a 5..8 scan.
  - Expect it to be ignored: only idx 5..8 are emitted and a single `done`.
